// File: rtl/shift_serdes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_serdes_pkg                                                |
// | Function : Shared types and helpers for the shift-register serdes block.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package shift_serdes_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   // Bits needed to hold 0..max_count; never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_serdes_ctrl_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_reg_sl                                                    |
// | Function : Shift-left register with synchronous parallel load, serial in   |
// |            at the LSB and serial out from the MSB. Load beats shift.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_reg_sl
   import shift_serdes_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             shift_en,
   input  logic             sin,
   output logic             sout,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Next register value: parallel load first, otherwise shift sin into the LSB.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = din;
      end else if (shift_en) begin
         q_d = {q_q[WIDTH-2:0], sin};
      end
   end

   // Register storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q    = q_q;
   assign sout = q_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/shift_serdes_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_serdes_ctrl                                               |
// | Function : Frame sequencer around a shift-left register: accepts a word    |
// |            via valid/ready, shifts it out MSB-first while capturing sin,   |
// |            then strobes the captured word on rx_valid/rx_data.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_serdes_ctrl
   import shift_serdes_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int IDLE_GAP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   input  logic             abort,
   input  logic             sin,
   output logic             sout,
   output logic             frame,
   output logic             busy,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data
);

   localparam int c_cnt_w = cnt_width(WIDTH);
   localparam int c_gap_w = cnt_width(IDLE_GAP);
   localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
   localparam logic [c_gap_w-1:0] c_last_gap = c_gap_w'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   state_e               state_d,   state_q;
   logic [c_cnt_w-1:0]   bit_cnt_d, bit_cnt_q;
   logic [c_gap_w-1:0]   gap_cnt_d, gap_cnt_q;
   logic [WIDTH-1:0]     rx_data_d, rx_data_q;

   logic                 w_load;
   logic                 w_shift_en;
   logic                 w_sr_sout;
   logic [WIDTH-1:0]     w_sr_q;
   logic                 w_framing;

   shift_reg_sl #(
      .WIDTH    (WIDTH)
   ) u_shift_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .din      (tx_data),
      .shift_en (w_shift_en),
      .sin      (sin),
      .sout     (w_sr_sout),
      .q        (w_sr_q)
   );

   // Next-state, counters and register controls; abort outranks normal flow.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rx_data_d  = rx_data_q;
      w_load     = 1'b0;
      w_shift_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               w_load    = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               w_shift_en = 1'b1;
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == c_last_bit) begin
                  // Capture the word as it will look after this final shift.
                  rx_data_d = (w_sr_q << 1) | WIDTH'(sin);
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            gap_cnt_d = '0;
            state_d   = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (abort || (gap_cnt_q == c_last_gap)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign w_framing = (state_q == ST_SHIFT);
   assign tx_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign frame     = w_framing;
   assign sout      = w_framing & w_sr_sout;
   assign rx_valid  = (state_q == ST_DONE);
   assign rx_data   = rx_data_q;

endmodule
`default_nettype wire
